// File: rtl/scarv_cop_palu_shift_stage_pkg.sv
// Shared COP encodings: pack-width codes, packed-ALU shift ops, lane-width lookup
// and the pipeline payload records used by the shift stage.
package scarv_cop_palu_shift_stage_pkg;

  localparam logic [2:0] SCARV_COP_PW_1  = 3'd1;
  localparam logic [2:0] SCARV_COP_PW_2  = 3'd2;
  localparam logic [2:0] SCARV_COP_PW_4  = 3'd3;
  localparam logic [2:0] SCARV_COP_PW_8  = 3'd4;
  localparam logic [2:0] SCARV_COP_PW_16 = 3'd5;

  localparam logic [1:0] SCARV_COP_PALU_SLL  = 2'b00;
  localparam logic [1:0] SCARV_COP_PALU_SRL  = 2'b01;
  localparam logic [1:0] SCARV_COP_PALU_ROTL = 2'b10;
  localparam logic [1:0] SCARV_COP_PALU_ROTR = 2'b11;

  // Lane width in bits for a pack-width code; 0 marks an illegal code.
  function automatic logic [5:0] scarv_cop_pw_width(input logic [2:0] pw);
    case (pw)
      SCARV_COP_PW_1:  return 6'd32;
      SCARV_COP_PW_2:  return 6'd16;
      SCARV_COP_PW_4:  return 6'd8;
      SCARV_COP_PW_8:  return 6'd4;
      SCARV_COP_PW_16: return 6'd2;
      default:         return 6'd0;
    endcase
  endfunction

  function automatic logic scarv_cop_pw_legal(input logic [2:0] pw);
    return scarv_cop_pw_width(pw) != 6'd0;
  endfunction

  // In-lane bit-position mask (W-1); zero for illegal codes.
  function automatic logic [4:0] scarv_cop_pw_mask(input logic [2:0] pw);
    logic [5:0] w_m1;
    w_m1 = scarv_cop_pw_width(pw) - 6'd1;
    return scarv_cop_pw_legal(pw) ? w_m1[4:0] : 5'd0;
  endfunction

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  pw;
    logic [31:0] crs1;
    logic [3:0]  rd;
    logic [4:0]  n;
  } s1_payload_t;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  rd;
    logic        err;
  } s2_payload_t;

endpackage

// File: rtl/scarv_cop_palu_shifter.sv
// Combinational packed shifter: per-lane SLL (sl), SRL, or rotate-left (r) of a by shamt.
// Shifts by >= lane width give zero; rotates use shamt mod lane width; illegal pw gives zero.
module scarv_cop_palu_shifter
  import scarv_cop_palu_shift_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [5:0]  shamt,
  input  logic [2:0]  pw,
  input  logic        sl,
  input  logic        r,
  output logic [31:0] c
);

  logic       legal;
  logic [4:0] mask;
  logic [4:0] rot_amt;
  logic [4:0] idx;
  logic [4:0] pos;
  logic [4:0] base;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves one holding its old value (no latch).
    c       = '0;
    idx     = '0;
    pos     = '0;
    base    = '0;
    legal   = scarv_cop_pw_legal(pw);
    mask    = scarv_cop_pw_mask(pw);
    rot_amt = shamt[4:0] & mask;
    for (int i = 0; i < 32; i++) begin
      idx  = 5'(i);
      pos  = idx & mask;
      base = idx & ~mask;
      if (!legal) begin
        c[i] = 1'b0;
      end else if (r) begin
        c[i] = a[base | ((pos - rot_amt) & mask)];
      end else if (sl) begin
        if ({1'b0, pos} >= shamt) c[i] = a[base | (pos - shamt[4:0])];
      end else begin
        if ((7'(pos) + 7'(shamt)) <= 7'(mask)) c[i] = a[base | (pos + shamt[4:0])];
      end
    end
  end

endmodule

// File: rtl/scarv_cop_palu_shift_stage.sv
// Two-stage issue/capture wrapper around scarv_cop_palu_shifter with valid/ready
// handshakes, per-width amount normalisation and a synchronous flush.
module scarv_cop_palu_shift_stage
  import scarv_cop_palu_shift_stage_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        ivalid,
  output logic        iready,
  input  logic [1:0]  op,
  input  logic [2:0]  pw,
  input  logic [31:0] crs1,
  input  logic [31:0] crs2,
  input  logic [5:0]  imm,
  input  logic        use_imm,
  input  logic [3:0]  rd,
  output logic        ovalid,
  input  logic        oready,
  output logic [31:0] result,
  output logic [3:0]  rd_o,
  output logic        err
);

  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  s1_payload_t s1_q, s1_d;
  s2_payload_t s2_q, s2_d;

  logic        adv2;
  logic        accept;
  logic        s1_move;
  logic [5:0]  amt;
  logic [4:0]  lane_mask;
  logic [4:0]  m;
  logic [31:0] shift_c;
  logic        unused_crs2;

  assign adv2    = !s2_valid_q || oready;
  assign iready  = !s1_valid_q || adv2;
  assign accept  = ivalid && iready;
  assign s1_move = s1_valid_q && adv2;

  assign unused_crs2 = ^crs2[31:6];

  // Lane widths are powers of two, so (W - m) mod W is just -m masked to the lane.
  always_comb begin
    amt       = use_imm ? imm : crs2[5:0];
    lane_mask = scarv_cop_pw_mask(pw);
    m         = amt[4:0] & lane_mask;
    s1_d.op   = op;
    s1_d.pw   = pw;
    s1_d.crs1 = crs1;
    s1_d.rd   = rd;
    s1_d.n    = (op == SCARV_COP_PALU_ROTR) ? ((5'd0 - m) & lane_mask) : m;
  end

  scarv_cop_palu_shifter i_shifter (
    .a     (s1_q.crs1),
    .shamt ({1'b0, s1_q.n}),
    .pw    (s1_q.pw),
    .sl    (s1_q.op == SCARV_COP_PALU_SLL),
    .r     (s1_q.op[1]),
    .c     (shift_c)
  );

  always_comb begin
    s2_d.err    = !scarv_cop_pw_legal(s1_q.pw);
    s2_d.result = s2_d.err ? 32'd0 : shift_c;
    s2_d.rd     = s1_q.rd;
  end

  // Later assignments win: accept refills S1 after a move, flush overrides both.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_move) s1_valid_d = 1'b0;
    if (accept)  s1_valid_d = 1'b1;
    if (flush)   s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (oready)  s2_valid_d = 1'b0;
    if (s1_move) s2_valid_d = 1'b1;
    if (flush)   s2_valid_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // NOTE: S1 payload is not reset; it is only observed while s1_valid_q is set.
  always_ff @(posedge g_clk) begin
    if (accept) s1_q <= s1_d;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      s2_q <= '0;
    end else if (s1_move) begin
      s2_q <= s2_d;
    end
  end

  assign ovalid = s2_valid_q;
  assign result = s2_q.result;
  assign rd_o   = s2_q.rd;
  assign err    = s2_q.err;

endmodule

// File: tb/tb_scarv_cop_palu_shift_stage.sv
// Scoreboard bench for scarv_cop_palu_shift_stage: directed cases, backpressure,
// flush and reset kills, then randomized traffic against a lane-arithmetic model.
module tb_scarv_cop_palu_shift_stage;
  import scarv_cop_palu_shift_stage_pkg::*;

  logic        g_clk;
  logic        g_resetn;
  logic        flush;
  logic        ivalid;
  logic        iready;
  logic [1:0]  op;
  logic [2:0]  pw;
  logic [31:0] crs1;
  logic [31:0] crs2;
  logic [5:0]  imm;
  logic        use_imm;
  logic [3:0]  rd;
  logic        ovalid;
  logic        oready;
  logic [31:0] result;
  logic [3:0]  rd_o;
  logic        err;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   oready_rand = 0;

  scarv_cop_palu_shift_stage dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .flush    (flush),
    .ivalid   (ivalid),
    .iready   (iready),
    .op       (op),
    .pw       (pw),
    .crs1     (crs1),
    .crs2     (crs2),
    .imm      (imm),
    .use_imm  (use_imm),
    .rd       (rd),
    .ovalid   (ovalid),
    .oready   (oready),
    .result   (result),
    .rd_o     (rd_o),
    .err      (err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: slice crs1 into lanes and apply the shift/rotate with plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [2:0] p, input logic [31:0] a,
                                 input logic [5:0] amt, input logic [3:0] d);
    exp_t        e;
    int          w;
    int          k;
    logic [63:0] lmask, v, r, acc;
    e.rd  = d;
    e.err = 1'b0;
    e.res = '0;
    case (p)
      3'd1:    w = 32;
      3'd2:    w = 16;
      3'd3:    w = 8;
      3'd4:    w = 4;
      3'd5:    w = 2;
      default: w = 0;
    endcase
    if (w == 0) begin
      e.err = 1'b1;
      return e;
    end
    k     = int'(amt) % w;
    lmask = (64'd1 << w) - 64'd1;
    acc   = '0;
    for (int l = 0; l < 32 / w; l++) begin
      v = (64'(a) >> (l * w)) & lmask;
      case (o)
        2'b00:   r = (v << k) & lmask;
        2'b01:   r = v >> k;
        2'b10:   r = ((v << k) | (v >> (w - k))) & lmask;
        default: r = ((v >> k) | (v << (w - k))) & lmask;
      endcase
      acc = acc | (r << (l * w));
    end
    e.res = acc[31:0];
    return e;
  endfunction

  // Presents one instruction from posedge+1 until accepted; leaves ivalid high on return.
  task automatic send(input logic [1:0] o, input logic [2:0] p, input logic [31:0] a,
                      input logic [31:0] b, input logic [5:0] im, input logic ui,
                      input logic [3:0] d, input exp_t e);
    bit done = 0;
    ivalid = 1'b1; op = o; pw = p; crs1 = a; crs2 = b; imm = im; use_imm = ui; rd = d;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge g_clk);
      if (iready) begin
        if (!flush && g_resetn) sb.push_back(e);
        done = 1;
      end
      @(posedge g_clk);
      #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_rand();
    logic [1:0]  o  = 2'($urandom_range(3));
    logic [2:0]  p  = ($urandom_range(9) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(5, 1));
    logic [31:0] a  = $urandom;
    logic [31:0] b  = $urandom;
    logic [5:0]  im = 6'($urandom_range(63));
    logic        ui = 1'($urandom_range(1));
    logic [3:0]  d  = 4'($urandom_range(15));
    send(o, p, a, b, im, ui, d, model(o, p, a, ui ? im : b[5:0], d));
  endtask

  task automatic drain();
    ivalid = 1'b0;
    oready_rand = 0;
    oready = 1'b1;
    for (int t = 0; t < 50 && (sb.size() != 0 || ovalid); t++) begin
      @(posedge g_clk);
      #2;
    end
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every cycle ovalid is high the outputs must match the oldest expectation.
  always @(negedge g_clk) begin
    exp_t e;
    if (ovalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_ovalid", 32'(ovalid), 32'd0);
      end else begin
        e = sb[0];
        check("result", result, e.res);
        check("rd_o", 32'(rd_o), 32'(e.rd));
        check("err", 32'(err), 32'(e.err));
        if (oready) void'(sb.pop_front());
      end
    end
    if (flush || !g_resetn) sb.delete();
  end

  always @(posedge g_clk) begin
    #2;
    if (oready_rand) oready = ($urandom_range(3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r32;
    exp_t        e;
    g_resetn = 1'b0; flush = 1'b0; ivalid = 1'b0; oready = 1'b1;
    op = '0; pw = '0; crs1 = '0; crs2 = '0; imm = '0; use_imm = 1'b0; rd = '0;
    repeat (2) @(posedge g_clk);
    #1 g_resetn = 1'b1;
    @(negedge g_clk);
    check("reset_ovalid", 32'(ovalid), 32'd0);
    check("reset_iready", 32'(iready), 32'd1);
    check("reset_result", result, 32'd0);
    check("reset_rd_o", 32'(rd_o), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(posedge g_clk);
    #1;

    // Latency: ovalid two edges after accept.
    e = '{res: 32'h0000_0F10, rd: 4'd3, err: 1'b0};
    send(SCARV_COP_PALU_SLL, SCARV_COP_PW_1, 32'h0000_00F1, 32'd0, 6'd4, 1'b1, 4'd3, e);
    ivalid = 1'b0;
    @(negedge g_clk);
    check("latency_edge1_ovalid", 32'(ovalid), 32'd0);
    @(negedge g_clk);
    check("latency_edge2_ovalid", 32'(ovalid), 32'd1);
    @(posedge g_clk);
    #1;

    e = '{res: 32'hC080_0181, rd: 4'd1, err: 1'b0};
    send(SCARV_COP_PALU_ROTR, SCARV_COP_PW_4, 32'h8101_0203, 32'd1, 6'd0, 1'b0, 4'd1, e);
    e = '{res: 32'h7800_4000, rd: 4'd2, err: 1'b0};
    send(SCARV_COP_PALU_SRL, SCARV_COP_PW_2, 32'hF000_8000, 32'd0, 6'd17, 1'b1, 4'd2, e);
    r32 = $urandom;
    e = '{res: r32, rd: 4'd4, err: 1'b0};
    send(SCARV_COP_PALU_ROTL, SCARV_COP_PW_16, r32, 32'd0, 6'd2, 1'b1, 4'd4, e);
    e = '{res: 32'd0, rd: 4'd9, err: 1'b1};
    send(SCARV_COP_PALU_SRL, 3'd7, 32'hDEAD_BEEF, 32'd3, 6'd5, 1'b1, 4'd9, e);
    drain();

    // Backpressure: S1 and S2 fill, iready drops, and returns with oready.
    oready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          e = '{res: 32'(2 * i), rd: 4'(i), err: 1'b0};
          send(SCARV_COP_PALU_SLL, SCARV_COP_PW_1, 32'(i), 32'd0, 6'd1, 1'b1, 4'(i), e);
        end
        ivalid = 1'b0;
      end
      begin
        repeat (3) @(negedge g_clk);
        check("bp_iready_low", 32'(iready), 32'd0);
        repeat (2) @(negedge g_clk);
        check("bp_iready_still_low", 32'(iready), 32'd0);
        @(posedge g_clk);
        #1 oready = 1'b1;
        #1 check("bp_iready_same_cycle", 32'(iready), 32'd1);
      end
    join
    drain();

    // Flush with both stages full, a same-cycle offer, and a same-cycle consume.
    oready = 1'b0;
    e = '{res: 32'h0000_00A0, rd: 4'd5, err: 1'b0};
    send(SCARV_COP_PALU_SLL, SCARV_COP_PW_1, 32'h0000_0005, 32'd0, 6'd5, 1'b1, 4'd5, e);
    e = model(SCARV_COP_PALU_ROTL, SCARV_COP_PW_8, 32'h1234_5678, 6'd1, 4'd6);
    send(SCARV_COP_PALU_ROTL, SCARV_COP_PW_8, 32'h1234_5678, 32'd0, 6'd1, 1'b1, 4'd6, e);
    op = SCARV_COP_PALU_SRL; crs1 = 32'hFFFF_FFFF; rd = 4'd7;
    flush = 1'b1;
    oready = 1'b1;
    @(negedge g_clk);
    check("flush_iready_driven", 32'(iready), 32'd1);
    @(posedge g_clk);
    #1 flush = 1'b0; ivalid = 1'b0;
    @(negedge g_clk);
    check("flush_ovalid", 32'(ovalid), 32'd0);
    check("flush_iready", 32'(iready), 32'd1);
    repeat (4) @(posedge g_clk);
    #1;
    drain();

    // Reset pulse mid-stream discards everything in flight.
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand();
        ivalid = 1'b0;
      end
      begin
        repeat (3) @(posedge g_clk);
        #1 g_resetn = 1'b0;
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        @(negedge g_clk);
        check("midreset_ovalid", 32'(ovalid), 32'd0);
        check("midreset_iready", 32'(iready), 32'd1);
      end
    join
    drain();

    // Random traffic with random backpressure, idle gaps and occasional flushes.
    oready_rand = 1;
    for (int i = 0; i < 400; i++) begin
      int sel = $urandom_range(19);
      if (sel == 0) begin
        ivalid = 1'b0;
        flush = 1'b1;
        @(posedge g_clk);
        #1 flush = 1'b0;
      end else if (sel < 4) begin
        ivalid = 1'b0;
        @(posedge g_clk);
        #1;
      end else begin
        send_rand();
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
